// File: rtl/instr_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// address field positions, geometry and FSM state encoding.
package instr_cache_pkg;

    localparam int ADDR_W     = 10;
    localparam int IDX_W      = 3;
    localparam int OFF_W      = 4;
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;
    localparam int NUM_BLOCKS = 2 ** IDX_W;
    localparam int BLOCK_BITS = 128;
    localparam int WORD_W     = 32;
    localparam int BLK_ADDR_W = TAG_W + IDX_W;

    // Address field positions within the fetch byte address
    localparam int TAG_MSB  = 9;
    localparam int TAG_LSB  = 7;
    localparam int IDX_MSB  = 6;
    localparam int IDX_LSB  = 4;
    localparam int OFF_MSB  = 3;
    localparam int OFF_LSB  = 0;
    localparam int WSEL_MSB = 3;
    localparam int WSEL_LSB = 2;

    typedef enum logic [1:0] {
        IC_IDLE     = 2'd0,
        IC_MEM_READ = 2'd1,
        IC_UPDATE   = 2'd2
    } ic_state_e;

    // Block address {tag,index} of a fetch byte address
    function automatic logic [BLK_ADDR_W-1:0] block_addr(input logic [ADDR_W-1:0] pc);
        return pc[TAG_MSB:IDX_LSB];
    endfunction

endpackage

// File: rtl/instr_cache_if.sv
// Fetch-port and refill-port signals of the instruction cache.
// The cache is the slave; the CPU/memory side (or a testbench) is the master.
interface instr_cache_if;
    import instr_cache_pkg::*;

    logic [ADDR_W-1:0]     pc;
    logic                  read;
    logic [WORD_W-1:0]     instruction;
    logic                  busywait;
    logic                  mem_read;
    logic [BLK_ADDR_W-1:0] mem_address;
    logic [BLOCK_BITS-1:0] mem_readdata;
    logic                  mem_busywait;

    modport slave (
        input  pc, read, mem_readdata, mem_busywait,
        output instruction, busywait, mem_read, mem_address
    );

    modport master (
        output pc, read, mem_readdata, mem_busywait,
        input  instruction, busywait, mem_read, mem_address
    );

endinterface

// File: rtl/instr_cache_word_select.sv
// 128-to-32 word multiplexer: picks one word of a cache block by PC[3:2].
module ic_word_select
    import instr_cache_pkg::*;
(
    input  logic [BLOCK_BITS-1:0] block,
    input  logic [1:0]            word_sel,
    output logic [WORD_W-1:0]     word
);

    // Select the addressed 32-bit word; word0 sits in the low bits
    always_comb begin
        word = block[31:0];
        case (word_sel)
            2'd0:    word = block[31:0];
            2'd1:    word = block[63:32];
            2'd2:    word = block[95:64];
            2'd3:    word = block[127:96];
            default: word = block[31:0];
        endcase
    end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache (8 blocks x 16 bytes).
// Hits return the word in the same cycle; a miss stalls the CPU via
// busywait while a whole block is refilled over the 128-bit memory bus.
module instr_cache
    import instr_cache_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    instr_cache_if.slave  bus
);

    ic_state_e             state_r;
    ic_state_e             state_next_s;

    logic [NUM_BLOCKS-1:0] valid_r;
    logic [TAG_W-1:0]      tag_r  [NUM_BLOCKS];
    logic [BLOCK_BITS-1:0] data_r [NUM_BLOCKS];

    logic [BLK_ADDR_W-1:0] miss_addr_r;
    logic [BLOCK_BITS-1:0] refill_r;
    logic [WORD_W-1:0]     last_instr_r;

    logic [TAG_W-1:0]      tag_s;
    logic [IDX_W-1:0]      idx_s;
    logic [1:0]            wsel_s;
    logic [IDX_W-1:0]      fill_idx_s;
    logic                  hit_s;
    logic                  miss_s;
    logic [WORD_W-1:0]     word_s;

    logic                  busywait_s;
    logic                  mem_read_s;
    logic [BLK_ADDR_W-1:0] mem_address_s;

    // Byte-within-word bits never matter for a word fetch
    logic                  unused_pc_s;
    assign unused_pc_s = ^bus.pc[1:0];

    assign tag_s      = bus.pc[TAG_MSB:TAG_LSB];
    assign idx_s      = bus.pc[IDX_MSB:IDX_LSB];
    assign wsel_s     = bus.pc[WSEL_MSB:WSEL_LSB];
    assign fill_idx_s = miss_addr_r[IDX_W-1:0];

    assign hit_s  = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    assign miss_s = bus.read && !hit_s;

    ic_word_select u_word_select (
        .block    (data_r[idx_s]),
        .word_sel (wsel_s),
        .word     (word_s)
    );

    // Output the looked-up word on a hit, otherwise hold the last fetched word
    assign bus.instruction = hit_s ? word_s : last_instr_r;
    assign bus.busywait    = busywait_s;
    assign bus.mem_read    = mem_read_s;
    assign bus.mem_address = mem_address_s;

    // Next-state and stall/refill outputs for the refill FSM
    always_comb begin
        state_next_s  = state_r;
        busywait_s    = 1'b0;
        mem_read_s    = 1'b0;
        mem_address_s = {BLK_ADDR_W{1'b0}};
        case (state_r)
            IC_IDLE: begin
                busywait_s = miss_s;
                if (miss_s) begin
                    state_next_s = IC_MEM_READ;
                end else begin
                    state_next_s = IC_IDLE;
                end
            end
            IC_MEM_READ: begin
                busywait_s    = 1'b1;
                mem_read_s    = 1'b1;
                mem_address_s = miss_addr_r;
                if (bus.mem_busywait) begin
                    state_next_s = IC_MEM_READ;
                end else begin
                    state_next_s = IC_UPDATE;
                end
            end
            IC_UPDATE: begin
                busywait_s   = 1'b1;
                state_next_s = IC_IDLE;
            end
            default: begin
                state_next_s = IC_IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any refill in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IC_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latch the missing block address and capture the returning block
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_addr_r <= {BLK_ADDR_W{1'b0}};
            refill_r    <= {BLOCK_BITS{1'b0}};
        end else begin
            if ((state_r == IC_IDLE) && miss_s) begin
                miss_addr_r <= block_addr(bus.pc);
            end
            if ((state_r == IC_MEM_READ) && !bus.mem_busywait) begin
                refill_r <= bus.mem_readdata;
            end
        end
    end

    // Valid bits: cleared by reset, set when a refill is written
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= {NUM_BLOCKS{1'b0}};
        end else if (state_r == IC_UPDATE) begin
            valid_r[fill_idx_s] <= 1'b1;
        end
    end

    // Tag and data arrays are not reset; valid alone qualifies them
    always_ff @(posedge clk) begin
        if (!reset && (state_r == IC_UPDATE)) begin
            tag_r[fill_idx_s]  <= miss_addr_r[BLK_ADDR_W-1:IDX_W];
            data_r[fill_idx_s] <= refill_r;
        end
    end

    // Remember the most recent hit word so the output never floats to X
    always_ff @(posedge clk) begin
        if (reset) begin
            last_instr_r <= {WORD_W{1'b0}};
        end else if (hit_s) begin
            last_instr_r <= word_s;
        end
    end

endmodule
